fb_write_scheduler: RTL and testbench
=====================================

# fb_write_scheduler

Single-clock write-port scheduler for the 320x240x12 frame buffer. It shares the buffer's one write port between the camera capture stream and a processing-engine write-back requester, and generates the raster capture address. It also tracks frame boundaries and flags dropped or illegal writes. It sits in the write-clock domain and drives the frame buffer's `wraddress`/`data`/`wren` directly.

## Interface
- `PIX_W`, 12, pixel width
- `ADDR_W`, 17, frame-buffer address width
- `NPIX`, 76800, pixels per frame (last legal address 76799)
- `FAIR_N`, 8, consecutive camera grants with `proc_req` pending before one processing slot is forced
- `clk` in 1: write clock, same clock as the frame buffer write port
- `reset` in 1: asynchronous, active-high
- `capture_en` in 1: arm capture; sampled only on a `cam_vsync` rising edge
- `cam_vsync` in 1: camera frame sync, already synchronous to `clk`
- `cam_valid` in 1: one pixel on `cam_data` this cycle
- `cam_data` in PIX_W: camera pixel
- `proc_req` in 1: processing write request; held with addr/data until granted
- `proc_addr` in ADDR_W: processing write address
- `proc_data` in PIX_W: processing write data
- `proc_grant` out 1: processing request taken this cycle
- `fb_wraddress` out ADDR_W: frame buffer write address, registered
- `fb_data` out PIX_W: frame buffer write data, registered
- `fb_wren` out 1: frame buffer write enable, registered
- `frame_done` out 1: 1-cycle pulse when pixel address 76799 is written
- `cam_overflow` out 1: sticky; a camera pixel was dropped
- `addr_err` out 1: sticky; a processing request had `proc_addr` ≥ NPIX

## Operation
- FSM states: WAIT_VS, CAPTURE, FULL.
  - Reset → WAIT_VS.
  - `cam_vsync` rising edge with `capture_en`=1, from any state → CAPTURE. `cap_addr` ← 0, FIFO flushed, `cam_overflow` cleared.
  - `cam_vsync` rising edge with `capture_en`=0 → WAIT_VS.
  - CAPTURE → FULL when pixel 76800 (address 76799) is pushed.
- Camera pixels enter a 4-deep FIFO only in CAPTURE. In WAIT_VS and FULL, `cam_valid` is ignored and no flag is set.
- FIFO full with `cam_valid`=1 → pixel dropped, `cam_overflow`←1, `cap_addr` not advanced. Each pushed pixel carries its address. `cap_addr` increments per push and never exceeds 76799.
- Arbitration, evaluated each cycle:
  - FIFO empty → grant `proc_req` if set.
  - FIFO non-empty → pop camera, unless `fair_cnt`=FAIR_N and `proc_req`=1. In that case grant processing and clear `fair_cnt`.
  - `fair_cnt` increments on each camera pop while `proc_req`=1.
  - `fair_cnt` clears on any processing grant or when `proc_req`=0.
- Processing grant with `proc_addr` ≥ NPIX: `proc_grant`=1 (request consumed), `fb_wren` stays 0, `addr_err`←1. `addr_err` is cleared only by reset.
- Camera rate contract: at most one `cam_valid` per 2 cycles, so the FIFO absorbs a forced processing slot without loss.

## Timing
- Reset values: `fb_wren`=0, `fb_wraddress`=0, `fb_data`=0, `proc_grant`=0, `frame_done`=0, `cam_overflow`=0, `addr_err`=0, `fair_cnt`=0, FIFO empty.
- Camera latency: `cam_valid` at cycle t (FIFO empty, no forced slot) → `fb_wren`=1 with that pixel and address in cycle t+2.
- Processing latency: `proc_grant` is combinational in cycle t. `fb_wren` with `proc_addr`/`proc_data` follows in cycle t+1. The requester may change addr/data at t+1.
- `frame_done` is asserted in the same cycle as `fb_wren` for address 76799.
- A vsync restart in the same cycle as a push: the flush wins and the pushed pixel is discarded.
- Asynchronous `reset` mid-frame: all state is cleared immediately, `fb_wren` deasserts with no partial write, FSM resumes in WAIT_VS.
- At most one write per cycle; `fb_wren` is never asserted on two consecutive cycles for the same source item.

## Structure
- Shared package `fb_pkg`: `FB_W`=320, `FB_H`=240, `FB_NPIX`=76800, `FB_ADDR_W`=17, `FB_PIX_W`=12, state encoding (WAIT_VS/CAPTURE/FULL). The same constants are reused by the read-side scanner.
- One sub-module: `fb_pixel_fifo`, a 4-deep synchronous FIFO, width PIX_W+ADDR_W, with flush, full, and empty.
- Top module holds the FSM, capture counter, fairness counter, arbiter, and output register.

## Test plan
- Full frame: vsync↑ with `capture_en`=1, then 76800 `cam_valid` pulses every 2 cycles → writes to addresses 0..76799 in order, `frame_done` pulses once, FSM reaches FULL, further `cam_valid` produces no writes.
- Latency: `cam_valid` at cycle 10 with data 0xABC → `fb_wren`=1, address 0, data 0xABC at cycle 12.
- Fairness: continuous camera traffic every 2 cycles plus `proc_req` held → `proc_grant` within 9 camera pops, zero drops, `cam_overflow`=0.
- Overflow: `cam_valid` every cycle with `proc_req` held for 20 cycles → `cam_overflow`=1, addresses stay contiguous over accepted pixels, flag clears on next vsync↑.
- Bad address: `proc_req` with `proc_addr`=76800 → `proc_grant`=1, no `fb_wren`, `addr_err`=1 and stays set.
- Reset mid-frame at pixel 1000 → all outputs 0 in the same cycle. A following vsync↑ restarts capture at address 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Frame-buffer geometry and write-scheduler state encoding shared by the
// write-side scheduler and the read-side scanner.
package fb_pkg;
    localparam int FB_W      = 320;
    localparam int FB_H      = 240;
    localparam int FB_NPIX   = FB_W * FB_H;
    localparam int FB_ADDR_W = 17;
    localparam int FB_PIX_W  = 12;

    localparam logic [1:0] ST_WAIT_VS = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;
endpackage

// File: rtl/fb_pixel_fifo.sv
// Small synchronous FIFO holding {address, pixel} camera entries between
// capture and the frame-buffer write port. DEPTH must be a power of two.
module fb_pixel_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;

    // Extra wrap bit on each pointer distinguishes full from empty.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop_data = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !flush)
            mem[wr_ptr[PW-1:0]] <= push_data;
    end
endmodule

// File: rtl/fb_write_scheduler.sv
// Shares the frame-buffer write port between raster camera capture and
// processing write-back, with frame tracking and drop/illegal-write flags.
module fb_write_scheduler
    import fb_pkg::*;
#(
    parameter int PIX_W  = FB_PIX_W,
    parameter int ADDR_W = FB_ADDR_W,
    parameter int NPIX   = FB_NPIX,
    parameter int FAIR_N = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture_en,
    input  logic              cam_vsync,
    input  logic              cam_valid,
    input  logic [PIX_W-1:0]  cam_data,
    input  logic              proc_req,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [PIX_W-1:0]  proc_data,
    output logic              proc_grant,
    output logic [ADDR_W-1:0] fb_wraddress,
    output logic [PIX_W-1:0]  fb_data,
    output logic              fb_wren,
    output logic              frame_done,
    output logic              cam_overflow,
    output logic              addr_err
);
    localparam int                FW        = ADDR_W + PIX_W;
    localparam int                CW        = $clog2(FAIR_N + 1);
    localparam logic [ADDR_W-1:0] NPIX_A    = ADDR_W'(NPIX);
    localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
    localparam logic [CW-1:0]     FAIR_MAX  = CW'(FAIR_N);
    localparam logic [CW-1:0]     FAIR_ONE  = 1;

    logic [1:0]        state;
    logic              vs_d;
    logic [ADDR_W-1:0] cap_addr;
    logic [CW-1:0]     fair_cnt;

    logic              vs_rise, restart, push, drop;
    logic              fifo_full, fifo_empty;
    logic [FW-1:0]     fifo_q;
    logic              cam_avail, force_proc, cam_pop, proc_ok;
    logic [ADDR_W-1:0] head_addr;
    logic [PIX_W-1:0]  head_data;

    assign vs_rise = cam_vsync & ~vs_d;
    assign restart = vs_rise & capture_en;

    // A vsync edge in the same cycle as a pixel discards that pixel.
    assign push = (state == ST_CAPTURE) & cam_valid & ~fifo_full & ~vs_rise;
    assign drop = (state == ST_CAPTURE) & cam_valid &  fifo_full & ~vs_rise;

    assign head_addr = fifo_q[FW-1:PIX_W];
    assign head_data = fifo_q[PIX_W-1:0];

    // Entries being flushed this cycle are never written out.
    assign cam_avail  = ~fifo_empty & ~restart;
    assign force_proc = proc_req & (fair_cnt == FAIR_MAX);
    assign cam_pop    = cam_avail & ~force_proc;
    assign proc_grant = proc_req & (~cam_avail | force_proc);
    assign proc_ok    = (proc_addr < NPIX_A);

    fb_pixel_fifo #(
        .WIDTH (FW),
        .DEPTH (4)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (restart),
        .push      (push),
        .push_data ({cap_addr, cam_data}),
        .pop       (cam_pop),
        .pop_data  (fifo_q),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_WAIT_VS;
            vs_d         <= 1'b0;
            cap_addr     <= '0;
            fair_cnt     <= '0;
            cam_overflow <= 1'b0;
            addr_err     <= 1'b0;
        end else begin
            vs_d <= cam_vsync;
            if (restart) begin
                state        <= ST_CAPTURE;
                cap_addr     <= '0;
                cam_overflow <= 1'b0;
            end else if (vs_rise) begin
                state <= ST_WAIT_VS;
            end else begin
                if (push) begin
                    if (cap_addr == LAST_A)
                        state <= ST_FULL;
                    else
                        cap_addr <= cap_addr + ADDR_ONE;
                end
                if (drop)
                    cam_overflow <= 1'b1;
            end
            if (proc_grant && !proc_ok)
                addr_err <= 1'b1;
            if (proc_grant || !proc_req)
                fair_cnt <= '0;
            else if (cam_pop)
                fair_cnt <= fair_cnt + FAIR_ONE;
        end
    end

    // Output register stage: the selected write reaches the frame buffer here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb_wren      <= 1'b0;
            frame_done   <= 1'b0;
            fb_wraddress <= '0;
            fb_data      <= '0;
        end else begin
            fb_wren    <= cam_pop | (proc_grant & proc_ok);
            frame_done <= cam_pop & (head_addr == LAST_A);
            if (cam_pop) begin
                fb_wraddress <= head_addr;
                fb_data      <= head_data;
            end else if (proc_grant && proc_ok) begin
                fb_wraddress <= proc_addr;
                fb_data      <= proc_data;
            end
        end
    end
endmodule

// File: tb/tb_fb_write_scheduler.sv
// Bench for fb_write_scheduler: directed vector table, multi-cycle corner
// sequences and random traffic checked against a queue-level reference model.
module tb_fb_write_scheduler;
    localparam int PIX_W  = 12;
    localparam int ADDR_W = 17;
    localparam int NPIX   = 64;   // reduced frame so whole frames fit in a short run
    localparam int FAIR_N = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              capture_en, cam_vsync, cam_valid, proc_req;
    logic [PIX_W-1:0]  cam_data, proc_data;
    logic [ADDR_W-1:0] proc_addr;
    logic              proc_grant, fb_wren, frame_done, cam_overflow, addr_err;
    logic [ADDR_W-1:0] fb_wraddress;
    logic [PIX_W-1:0]  fb_data;

    always #5 clk = ~clk;

    fb_write_scheduler #(
        .PIX_W(PIX_W), .ADDR_W(ADDR_W), .NPIX(NPIX), .FAIR_N(FAIR_N)
    ) dut (
        .clk(clk), .reset(reset), .capture_en(capture_en), .cam_vsync(cam_vsync),
        .cam_valid(cam_valid), .cam_data(cam_data), .proc_req(proc_req),
        .proc_addr(proc_addr), .proc_data(proc_data), .proc_grant(proc_grant),
        .fb_wraddress(fb_wraddress), .fb_data(fb_data), .fb_wren(fb_wren),
        .frame_done(frame_done), .cam_overflow(cam_overflow), .addr_err(addr_err)
    );

    int vecs = 0;
    int errs = 0;

    // Reference model: capture mode, pending-pixel queue, sticky flags, outputs.
    int                        m_mode;   // 0 idle, 1 capturing, 2 frame complete
    logic [ADDR_W+PIX_W-1:0]   m_q[$];
    int                        m_cap, m_fair;
    bit                        m_vs, m_ovf, m_aerr, m_wren, m_done;
    logic [ADDR_W-1:0]         m_addr;
    logic [PIX_W-1:0]          m_data;

    bit track;
    int seq_addr, wr_cnt, done_cnt;

    typedef struct {
        bit vs, en, cv;
        logic [PIX_W-1:0] cd;
        bit pr;
        logic [ADDR_W-1:0] pa;
        logic [PIX_W-1:0] pd;
        bit g, w;
        logic [ADDR_W-1:0] wa;
        logic [PIX_W-1:0] wd;
        bit ae;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_q.delete(); m_cap = 0; m_fair = 0;
        m_vs = 0; m_ovf = 0; m_aerr = 0; m_wren = 0; m_done = 0;
        m_addr = '0; m_data = '0;
    endtask

    function automatic void m_arb(output bit pop, output bit grant);
        bit avail, force_slot;
        avail      = (m_q.size() > 0) && !(cam_vsync && !m_vs && capture_en);
        force_slot = proc_req && (m_fair == FAIR_N);
        pop        = avail && !force_slot;
        grant      = proc_req && (!avail || force_slot);
    endfunction

    task automatic at_neg();
        bit pop, grant;
        @(negedge clk);
        m_arb(pop, grant);
        chk("grant", proc_grant, grant);
        chk("wren", fb_wren, m_wren);
        chk("waddr", fb_wraddress, m_addr);
        chk("wdata", fb_data, m_data);
        chk("done", frame_done, m_done);
        chk("ovf", cam_overflow, m_ovf);
        chk("aerr", addr_err, m_aerr);
        wr_cnt   += int'(fb_wren);
        done_cnt += int'(frame_done);
        if (track && fb_wren) begin
            chk("seq", fb_wraddress, seq_addr);
            seq_addr++;
        end
    endtask

    task automatic m_update();
        bit pop, grant, rise, full;
        logic [ADDR_W+PIX_W-1:0] it;
        m_arb(pop, grant);
        rise = cam_vsync && !m_vs;
        full = (m_q.size() >= 4);
        if (pop) begin
            it = m_q.pop_front();
            m_wren = 1; m_addr = it[ADDR_W+PIX_W-1:PIX_W]; m_data = it[PIX_W-1:0];
            m_done = (m_addr == NPIX - 1);
        end else if (grant && proc_addr < NPIX) begin
            m_wren = 1; m_addr = proc_addr; m_data = proc_data; m_done = 0;
        end else begin
            m_wren = 0; m_done = 0;
        end
        if (grant && proc_addr >= NPIX) m_aerr = 1;
        if (grant || !proc_req) m_fair = 0;
        else if (pop) m_fair++;
        if (rise && capture_en) begin
            m_q.delete(); m_cap = 0; m_ovf = 0; m_mode = 1;
        end else if (rise) begin
            m_mode = 0;
        end else if (m_mode == 1 && cam_valid) begin
            if (full) m_ovf = 1;
            else begin
                m_q.push_back({ADDR_W'(m_cap), cam_data});
                if (m_cap == NPIX - 1) m_mode = 2;
                else m_cap++;
            end
        end
        m_vs = cam_vsync;
    endtask

    task automatic fin();
        m_update();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        at_neg();
        fin();
    endtask

    task automatic vs_pulse(input bit en);
        cam_valid = 0; capture_en = en; cam_vsync = 1;
        cyc();
        cam_vsync = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int maxrun, run, dens;
        bit hit, g;

        tbl[0]  = '{0,1,0,12'h000,0,17'd0, 12'h000, 0,0,17'd0,12'h000,0};
        tbl[1]  = '{1,1,0,12'h000,0,17'd0, 12'h000, 0,0,17'd0,12'h000,0};
        tbl[2]  = '{0,1,1,12'hABC,0,17'd0, 12'h000, 0,0,17'd0,12'h000,0};
        tbl[3]  = '{0,1,0,12'h000,1,17'd5, 12'h123, 0,0,17'd0,12'h000,0};
        tbl[4]  = '{0,1,0,12'h000,1,17'd5, 12'h123, 1,1,17'd0,12'hABC,0};
        tbl[5]  = '{0,1,0,12'h000,0,17'd0, 12'h000, 0,1,17'd5,12'h123,0};
        tbl[6]  = '{0,1,0,12'h000,1,17'd64,12'h777, 1,0,17'd5,12'h123,0};
        tbl[7]  = '{0,1,0,12'h000,0,17'd0, 12'h000, 0,0,17'd5,12'h123,1};
        tbl[8]  = '{0,1,1,12'h456,0,17'd0, 12'h000, 0,0,17'd5,12'h123,1};
        tbl[9]  = '{0,1,0,12'h000,0,17'd0, 12'h000, 0,0,17'd5,12'h123,1};
        tbl[10] = '{0,1,0,12'h000,0,17'd0, 12'h000, 0,1,17'd1,12'h456,1};

        reset = 1; capture_en = 0; cam_vsync = 0; cam_valid = 0; cam_data = '0;
        proc_req = 0; proc_addr = '0; proc_data = '0;
        track = 0; seq_addr = 0; wr_cnt = 0; done_cnt = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wren", fb_wren, 0);
        chk("rst_addr", fb_wraddress, 0);
        chk("rst_data", fb_data, 0);
        chk("rst_grant", proc_grant, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ovf", cam_overflow, 0);
        chk("rst_aerr", addr_err, 0);
        @(posedge clk); #1;
        reset = 0;

        // Directed table: latency, arbitration, bad address.
        for (int i = 0; i < 11; i++) begin
            cam_vsync = tbl[i].vs; capture_en = tbl[i].en; cam_valid = tbl[i].cv;
            cam_data = tbl[i].cd; proc_req = tbl[i].pr; proc_addr = tbl[i].pa;
            proc_data = tbl[i].pd;
            at_neg();
            chk("t_grant", proc_grant, tbl[i].g);
            chk("t_wren", fb_wren, tbl[i].w);
            chk("t_waddr", fb_wraddress, tbl[i].wa);
            chk("t_wdata", fb_data, tbl[i].wd);
            chk("t_aerr", addr_err, tbl[i].ae);
            fin();
        end
        proc_req = 0; cam_valid = 0;

        // Full frame with one pixel every two cycles.
        vs_pulse(1);
        track = 1; seq_addr = 0; wr_cnt = 0; done_cnt = 0;
        for (int i = 0; i < NPIX; i++) begin
            cam_valid = 1; cam_data = PIX_W'($urandom);
            cyc();
            cam_valid = 0;
            cyc();
        end
        repeat (2) cyc();
        chk("frm_wr", wr_cnt, NPIX);
        chk("frm_done", done_cnt, 1);
        chk("frm_seq", seq_addr, NPIX);
        wr_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cam_valid = 1; cam_data = PIX_W'($urandom);
            cyc();
            cam_valid = 0;
            cyc();
        end
        repeat (2) cyc();
        chk("full_ign", wr_cnt, 0);
        track = 0;

        // Back-to-back camera pixels with a held request: fairness, then overflow.
        vs_pulse(1);
        track = 1; seq_addr = 0; maxrun = 0; run = 0;
        proc_req = 1; proc_addr = 17'h1FFFF; proc_data = 12'h0F0;
        for (int i = 0; i < 60; i++) begin
            cam_valid = 1; cam_data = PIX_W'($urandom);
            at_neg();
            if (proc_req && !proc_grant) run++;
            else run = 0;
            if (run > maxrun) maxrun = run;
            fin();
        end
        cam_valid = 0; proc_req = 0;
        repeat (6) cyc();
        chk("fair_run", maxrun, FAIR_N);
        chk("ovf_set", cam_overflow, 1);
        track = 0;
        vs_pulse(1);
        cyc();
        chk("ovf_clr", cam_overflow, 0);
        chk("aerr_stk", addr_err, 1);

        // Asynchronous reset in a cycle where a capture write is on the port.
        wr_cnt = 0; hit = 0;
        for (int i = 0; i < 200; i++) begin
            cam_valid = (i % 2 == 0); cam_data = PIX_W'($urandom);
            at_neg();
            if (fb_wren && wr_cnt >= 10) begin
                hit = 1;
                break;
            end
            fin();
        end
        chk("rst_hit", hit, 1);
        #1 reset = 1;
        #1;
        chk("arst_wren", fb_wren, 0);
        chk("arst_addr", fb_wraddress, 0);
        chk("arst_data", fb_data, 0);
        chk("arst_done", frame_done, 0);
        chk("arst_aerr", addr_err, 0);
        chk("arst_ovf", cam_overflow, 0);
        cam_valid = 0;
        model_reset();
        @(posedge clk); #1;
        reset = 0;
        vs_pulse(1);
        track = 1; seq_addr = 0; wr_cnt = 0;
        cam_valid = 1; cam_data = 12'h5A5;
        cyc();
        cam_valid = 0;
        repeat (2) cyc();
        chk("rst_wr", wr_cnt, 1);
        chk("rst_seq", seq_addr, 1);
        track = 0;

        // Random traffic against the reference model.
        dens = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 0) dens = $urandom_range(10, 100);
            cam_vsync  = ($urandom_range(0, 199) == 0);
            capture_en = ($urandom_range(0, 9) != 0);
            cam_valid  = ($urandom_range(0, 99) < dens);
            cam_data   = PIX_W'($urandom);
            if (!proc_req && $urandom_range(0, 3) == 0) begin
                proc_req  = 1;
                proc_addr = ($urandom_range(0, 7) == 0) ? ADDR_W'(NPIX + $urandom_range(0, 1000))
                                                        : ADDR_W'($urandom_range(0, NPIX - 1));
                proc_data = PIX_W'($urandom);
            end
            at_neg();
            g = proc_grant;
            fin();
            if (g) proc_req = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
